z80_print_capture: RTL and testbench
====================================

Name: z80_print_capture

Overview:
- Synthesizable bus monitor downstream of z80cpu; watches its memory-write cycles for writes to a print-port address.
- Filters captured bytes through the console control-code rules, buffers the results in a FIFO, and presents them as a valid/ready character stream.
- Also counts Z80 CLK cycles until HALT and raises a done flag.
- Lets the CPU test harness run on FPGA with a UART/log sink in place of simulator prints.

Parameters:
- PRINT_ADDR, 16'h1234: memory address treated as the print port.
- FIFO_DEPTH, 16: character FIFO entries; must be a power of 2, minimum 2.

Ports:
- MCLK  in  1  master clock; the only clock in the block.
- RESET  in  1  asynchronous, active-low reset.
- CLK  in  1  Z80 clock; treated as data and sampled on MCLK.
- ADDRESS  in  16  z80cpu address bus.
- ADDRESS_z  in  1  address bus tristated.
- DATA_o  in  8  z80cpu write data.
- DATA_z  in  1  data bus tristated.
- MREQ  in  1  active-low memory request.
- MREQ_z  in  1  MREQ tristated.
- WR  in  1  active-low write.
- WR_z  in  1  WR tristated.
- RFSH  in  1  active-low refresh.
- HALT  in  1  active-low halt.
- out_data  out  8  character byte.
- out_kind  out  2  0=CHAR, 1=NEWLINE, 2=COPYRIGHT.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  sink accepts head.
- overflow  out  1  sticky; an entry was dropped because the FIFO was full.
- char_count  out  16  number of entries accepted into the FIFO; wraps.
- cyc_count  out  32  CLK rising edges since reset release; wraps.
- done  out  1  sticky; HALT was seen low.

Behaviour:
- Reset values: all outputs 0. FIFO empty, filter FSM in PASS, all input registers cleared (registered CLK=0; MREQ, WR, HALT, RFSH registered as 1).
- Input stage:
  - All bus inputs are registered once on MCLK.
  - mwr = !MREQ & !MREQ_z & !WR & !WR_z & RFSH & !ADDRESS_z, evaluated on the registered signals.
  - A write event is the 0->1 transition of mwr with registered ADDRESS==PRINT_ADDR.
  - ADDRESS and DATA_o are taken from the same registered sample as the transition.
  - If DATA_z=1 at the event, the event is ignored entirely: no FSM change, no push.
- Filter FSM, states PASS, SKIP2, SKIP1, advanced once per write event:
  - PASS: byte 13 -> push (0x0D, NEWLINE).
  - PASS: byte 23 -> push (0x20, CHAR), go to SKIP2.
  - PASS: byte 127 -> push (0x7F, COPYRIGHT).
  - PASS: any other byte -> push (byte, CHAR).
  - SKIP2: discard byte -> SKIP1.
  - SKIP1: discard byte -> PASS.
  - A full FIFO never stalls the FSM.
- Latency:
  - The push occurs on the MCLK edge after the edge that registers mwr high.
  - out_valid rises 2 MCLK edges after mwr is first sampled high at the ports.
  - No bypass path for an empty FIFO.
- FIFO:
  - Pop occurs when out_valid & out_ready. out_data and out_kind hold steady while out_valid=1 and out_ready=0.
  - Push while full and no pop: entry dropped, overflow set, char_count unchanged.
  - Push while full with pop in the same cycle: push accepted, occupancy unchanged.
  - Push and pop while empty: push accepted; out_valid is 1 on the next cycle.
  - Pointers wrap modulo FIFO_DEPTH, with an extra bit to distinguish full from empty.
- Cycle counter:
  - Rising-edge detect on registered CLK.
  - cyc_count increments on each detected edge while done=0.
  - done is set when registered HALT=0; from that cycle cyc_count freezes.
  - An edge detected in the same cycle HALT is first seen low is not counted.
  - done and overflow clear only on RESET.
- Reset mid-operation (RESET low at any time, including mid-write or with FIFO partially full): everything clears asynchronously. Entries and skip state are lost. The first mwr transition after release is a fresh event.

Decomposition:
- Package z80_print_pkg holds:
  - kind_t enum (KIND_CHAR, KIND_NEWLINE, KIND_COPYRIGHT).
  - Constants CODE_NEWLINE=13, CODE_SKIP=23, CODE_COPYRIGHT=127, CODE_SPACE=8'h20.
  - Filter state enum (ST_PASS, ST_SKIP2, ST_SKIP1).
- One sub-module, z80_print_fifo: a synchronous FIFO of width 10 (data+kind), parameterized by depth, with push/pop/full/empty. It uses the same MCLK/RESET.

Test Plan:
- Write 0x48 to 0x1234, out_ready=1 -> one beat (0x48, CHAR); out_valid rises exactly 2 MCLK after mwr is sampled; char_count=1.
- Writes 0x0D then 0x7F -> beats (0x0D, NEWLINE) then (0x7F, COPYRIGHT), in order.
- Writes 0x17, 0x05, 0x0A, 0x41 -> exactly two beats, (0x20, CHAR) then (0x41, CHAR); FSM back in PASS.
- Each of the following produces no beat and leaves the FSM unchanged:
  - write to 0x1235;
  - MREQ/WR low with RFSH=0 at 0x1234;
  - write with MREQ_z=1;
  - write with DATA_z=1.
- out_ready=0, 17 writes of 0x30..0x40 -> out_valid=1, overflow=1, char_count=16. Draining yields 0x30..0x3F, then out_valid=0.
- Cycle counter:
  - 100 CLK periods after RESET release, then HALT=0 -> done=1, cyc_count=100, frozen through 20 further CLK periods.
  - Pulsing RESET low with 3 entries queued -> out_valid=0, done=0, cyc_count=0.

Source files
------------

// File: rtl/z80_print_pkg.sv
// Shared types and control codes for the Z80 print-port capture block.
package z80_print_pkg;

  typedef enum logic [1:0] {
    KIND_CHAR      = 2'd0,
    KIND_NEWLINE   = 2'd1,
    KIND_COPYRIGHT = 2'd2
  } kind_t;

  typedef enum logic [1:0] {
    ST_PASS  = 2'd0,
    ST_SKIP2 = 2'd1,
    ST_SKIP1 = 2'd2
  } filt_state_t;

  localparam logic [7:0] CODE_NEWLINE   = 8'd13;
  localparam logic [7:0] CODE_SKIP      = 8'd23;
  localparam logic [7:0] CODE_COPYRIGHT = 8'd127;
  localparam logic [7:0] CODE_SPACE     = 8'h20;

endpackage

// File: rtl/z80_print_fifo.sv
// Synchronous FIFO for filtered console entries; a push into a full FIFO is
// accepted only when a pop frees the head slot in the same cycle.
module z80_print_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 10
) (
  input  logic             MCLK,
  input  logic             RESET,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             push_ok
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic [WIDTH-1:0] mem_r [DEPTH];
  logic             full_s;
  logic             pop_ok_s;

  assign empty    = (wr_ptr_r == rd_ptr_r);
  assign full_s   = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                    (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign pop_ok_s = pop & ~empty;
  assign push_ok  = push & (~full_s | pop_ok_s);
  assign rdata    = mem_r[rd_ptr_r[AW-1:0]];

  // Storage and pointer update
  always_ff @(posedge MCLK or negedge RESET) begin
    if (!RESET) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        mem_r[wr_ptr_r[AW-1:0]] <= wdata;
        wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/z80_print_capture.sv
// Z80 bus monitor: captures print-port writes, applies console control-code
// filtering, queues the results, and counts Z80 clocks until HALT.
module z80_print_capture
  import z80_print_pkg::*;
#(
  parameter logic [15:0] PRINT_ADDR = 16'h1234,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic        MCLK,
  input  logic        RESET,
  input  logic        CLK,
  input  logic [15:0] ADDRESS,
  input  logic        ADDRESS_z,
  input  logic [7:0]  DATA_o,
  input  logic        DATA_z,
  input  logic        MREQ,
  input  logic        MREQ_z,
  input  logic        WR,
  input  logic        WR_z,
  input  logic        RFSH,
  input  logic        HALT,
  output logic [7:0]  out_data,
  output logic [1:0]  out_kind,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        overflow,
  output logic [15:0] char_count,
  output logic [31:0] cyc_count,
  output logic        done
);

  logic        clk_r, clk_d_r, addr_z_r, data_z_r, mreq_r, mreq_z_r;
  logic        wr_r, wr_z_r, rfsh_r, halt_r, mwr_d_r;
  logic [15:0] addr_r;
  logic [7:0]  data_r;
  logic        mwr_s, event_s, rise_s;

  filt_state_t state_r, state_next_s;
  logic        push_s, push_ok_s, fifo_empty_s;
  logic [7:0]  push_data_s;
  kind_t       push_kind_s;
  logic [9:0]  fifo_rdata_s;

  logic        overflow_r, done_r;
  logic [15:0] char_count_r;
  logic [31:0] cyc_count_r;

  assign mwr_s   = ~mreq_r & ~mreq_z_r & ~wr_r & ~wr_z_r & rfsh_r & ~addr_z_r;
  assign event_s = mwr_s & ~mwr_d_r & (addr_r == PRINT_ADDR) & ~data_z_r;
  assign rise_s  = clk_r & ~clk_d_r;

  // Input sampling stage; idle strobes reset to their inactive-high level
  always_ff @(posedge MCLK or negedge RESET) begin
    if (!RESET) begin
      clk_r    <= 1'b0;
      clk_d_r  <= 1'b0;
      addr_r   <= 16'h0000;
      addr_z_r <= 1'b0;
      data_r   <= 8'h00;
      data_z_r <= 1'b0;
      mreq_r   <= 1'b1;
      mreq_z_r <= 1'b0;
      wr_r     <= 1'b1;
      wr_z_r   <= 1'b0;
      rfsh_r   <= 1'b1;
      halt_r   <= 1'b1;
      mwr_d_r  <= 1'b0;
    end else begin
      clk_r    <= CLK;
      clk_d_r  <= clk_r;
      addr_r   <= ADDRESS;
      addr_z_r <= ADDRESS_z;
      data_r   <= DATA_o;
      data_z_r <= DATA_z;
      mreq_r   <= MREQ;
      mreq_z_r <= MREQ_z;
      wr_r     <= WR;
      wr_z_r   <= WR_z;
      rfsh_r   <= RFSH;
      halt_r   <= HALT;
      mwr_d_r  <= mwr_s;
    end
  end

  // Filter state register
  always_ff @(posedge MCLK or negedge RESET) begin
    if (!RESET) begin
      state_r <= ST_PASS;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Filter next-state and push decode; code 23 emits a space and eats two bytes
  always_comb begin
    state_next_s = state_r;
    push_s       = 1'b0;
    push_data_s  = 8'h00;
    push_kind_s  = KIND_CHAR;
    if (event_s) begin
      case (state_r)
        ST_PASS: begin
          push_s = 1'b1;
          if (data_r == CODE_NEWLINE) begin
            push_data_s = CODE_NEWLINE;
            push_kind_s = KIND_NEWLINE;
          end else if (data_r == CODE_SKIP) begin
            push_data_s  = CODE_SPACE;
            state_next_s = ST_SKIP2;
          end else if (data_r == CODE_COPYRIGHT) begin
            push_data_s = CODE_COPYRIGHT;
            push_kind_s = KIND_COPYRIGHT;
          end else begin
            push_data_s = data_r;
          end
        end
        ST_SKIP2: state_next_s = ST_SKIP1;
        ST_SKIP1: state_next_s = ST_PASS;
        default:  state_next_s = ST_PASS;
      endcase
    end else begin
      state_next_s = state_r;
    end
  end

  z80_print_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (10)
  ) u_fifo (
    .MCLK    (MCLK),
    .RESET   (RESET),
    .push    (push_s),
    .wdata   ({push_kind_s, push_data_s}),
    .pop     (out_ready),
    .rdata   (fifo_rdata_s),
    .empty   (fifo_empty_s),
    .push_ok (push_ok_s)
  );

  // Status counters; an edge coinciding with the first low HALT is not counted
  always_ff @(posedge MCLK or negedge RESET) begin
    if (!RESET) begin
      overflow_r   <= 1'b0;
      char_count_r <= 16'h0000;
      done_r       <= 1'b0;
      cyc_count_r  <= 32'h0000_0000;
    end else begin
      if (push_ok_s) begin
        char_count_r <= char_count_r + 16'd1;
      end
      if (push_s && !push_ok_s) begin
        overflow_r <= 1'b1;
      end
      if (!halt_r) begin
        done_r <= 1'b1;
      end
      if (rise_s && halt_r && !done_r) begin
        cyc_count_r <= cyc_count_r + 32'd1;
      end
    end
  end

  assign out_data   = fifo_rdata_s[7:0];
  assign out_kind   = fifo_rdata_s[9:8];
  assign out_valid  = ~fifo_empty_s;
  assign overflow   = overflow_r;
  assign char_count = char_count_r;
  assign cyc_count  = cyc_count_r;
  assign done       = done_r;

endmodule

// File: tb/tb_z80_print_capture.sv
// Scoreboard bench for z80_print_capture: directed bus writes push expected
// beats; a negedge monitor pops and compares every accepted output beat.
module tb_z80_print_capture;
  import z80_print_pkg::*;

  logic        MCLK = 1'b0;
  logic        RESET, CLK, ADDRESS_z, DATA_z, MREQ, MREQ_z, WR, WR_z, RFSH, HALT;
  logic [15:0] ADDRESS;
  logic [7:0]  DATA_o;
  logic [7:0]  out_data;
  logic [1:0]  out_kind;
  logic        out_valid, out_ready, overflow, done;
  logic [15:0] char_count;
  logic [31:0] cyc_count;

  int n_cmp = 0;
  int n_bad = 0;
  logic [9:0] sb_q[$];

  z80_print_capture dut (
    .MCLK(MCLK), .RESET(RESET), .CLK(CLK), .ADDRESS(ADDRESS), .ADDRESS_z(ADDRESS_z),
    .DATA_o(DATA_o), .DATA_z(DATA_z), .MREQ(MREQ), .MREQ_z(MREQ_z), .WR(WR),
    .WR_z(WR_z), .RFSH(RFSH), .HALT(HALT), .out_data(out_data), .out_kind(out_kind),
    .out_valid(out_valid), .out_ready(out_ready), .overflow(overflow),
    .char_count(char_count), .cyc_count(cyc_count), .done(done)
  );

  always #5 MCLK = ~MCLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge MCLK);
    #1;
  endtask

  task automatic expect_beat(input logic [7:0] d, input kind_t k);
    sb_q.push_back({k, d});
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d,
                           input logic rf, input logic mz, input logic dz);
    ADDRESS = a; DATA_o = d; RFSH = rf; MREQ_z = mz; DATA_z = dz;
    MREQ = 1'b0; WR = 1'b0;
    repeat (3) step();
    MREQ = 1'b1; WR = 1'b1; RFSH = 1'b1; MREQ_z = 1'b0; DATA_z = 1'b0;
    repeat (2) step();
  endtask

  task automatic wr(input logic [7:0] d);
    bus_write(16'h1234, d, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && sb_q.size() != 0; i++) step();
    check("drain_left", sb_q.size(), 0);
    repeat (3) step();
  endtask

  task automatic reset_pulse();
    RESET = 1'b0;
    repeat (2) step();
    RESET = 1'b1;
    step();
  endtask

  task automatic clk_periods(input int n);
    repeat (n) begin
      CLK = 1'b1;
      repeat (2) step();
      CLK = 1'b0;
      repeat (2) step();
    end
  endtask

  // Monitor: every accepted beat must match the scoreboard head
  initial begin
    logic [9:0] exp_beat;
    forever begin
      @(negedge MCLK);
      if (RESET && out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_beat: got %0h kind %0d expected none", out_data, out_kind);
        end else begin
          exp_beat = sb_q.pop_front();
          check("beat", {22'd0, out_kind, out_data}, {22'd0, exp_beat});
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [7:0] b;
    RESET = 1'b0; CLK = 1'b0; ADDRESS = 16'h0000; ADDRESS_z = 1'b0; DATA_o = 8'h00;
    DATA_z = 1'b0; MREQ = 1'b1; MREQ_z = 1'b0; WR = 1'b1; WR_z = 1'b0; RFSH = 1'b1;
    HALT = 1'b1; out_ready = 1'b0;
    repeat (3) step();
    RESET = 1'b1;
    step();
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_kind", out_kind, 0);
    check("rst_overflow", overflow, 0);
    check("rst_char_count", char_count, 0);
    check("rst_cyc_count", cyc_count, 0);
    check("rst_done", done, 0);

    // Single character with latency measurement
    out_ready = 1'b1;
    expect_beat(8'h48, KIND_CHAR);
    ADDRESS = 16'h1234; DATA_o = 8'h48; MREQ = 1'b0; WR = 1'b0;
    lat = 0;
    for (int i = 1; i <= 6; i++) begin
      step();
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    check("latency", lat, 2);
    repeat (2) step();
    MREQ = 1'b1; WR = 1'b1;
    repeat (2) step();
    drain();
    check("char_count_1", char_count, 1);

    // Newline and copyright codes
    expect_beat(8'h0D, KIND_NEWLINE);
    expect_beat(8'h7F, KIND_COPYRIGHT);
    wr(8'h0D);
    wr(8'h7F);
    drain();

    // Skip code consumes the next two bytes
    expect_beat(8'h20, KIND_CHAR);
    expect_beat(8'h41, KIND_CHAR);
    wr(8'h17); wr(8'h05); wr(8'h0A); wr(8'h41);
    drain();

    // Non-events inside a skip sequence must not advance it
    expect_beat(8'h20, KIND_CHAR);
    expect_beat(8'h43, KIND_CHAR);
    wr(8'h17);
    bus_write(16'h1235, 8'h50, 1'b1, 1'b0, 1'b0);
    bus_write(16'h1234, 8'h51, 1'b0, 1'b0, 1'b0);
    bus_write(16'h1234, 8'h52, 1'b1, 1'b1, 1'b0);
    bus_write(16'h1234, 8'h53, 1'b1, 1'b0, 1'b1);
    wr(8'h05); wr(8'h0A); wr(8'h43);
    drain();
    check("char_count_7", char_count, 7);

    // Overflow with a stalled sink
    reset_pulse();
    out_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      b = 8'h30 + 8'(i);
      if (i < 16) expect_beat(b, KIND_CHAR);
      wr(b);
    end
    check("ovf_valid", out_valid, 1);
    check("ovf_flag", overflow, 1);
    check("ovf_char_count", char_count, 16);
    repeat (4) step();
    check("hold_data", out_data, 8'h30);
    out_ready = 1'b1;
    drain();
    check("drained_valid", out_valid, 0);
    check("ovf_sticky", overflow, 1);

    // Cycle counter and HALT
    reset_pulse();
    clk_periods(50);
    check("cyc_50", cyc_count, 50);
    clk_periods(50);
    check("cyc_100", cyc_count, 100);
    check("done_before_halt", done, 0);
    HALT = 1'b0;
    repeat (3) step();
    check("done_set", done, 1);
    check("cyc_at_halt", cyc_count, 100);
    clk_periods(20);
    check("cyc_frozen", cyc_count, 100);
    check("done_sticky", done, 1);

    // Reset pulse with entries queued
    HALT = 1'b1;
    out_ready = 1'b0;
    wr(8'h61); wr(8'h62); wr(8'h63);
    check("queued_valid", out_valid, 1);
    check("queued_count", char_count, 3);
    RESET = 1'b0;
    #2;
    check("async_valid", out_valid, 0);
    check("async_done", done, 0);
    check("async_cyc", cyc_count, 0);
    check("async_count", char_count, 0);
    step();
    RESET = 1'b1;
    repeat (3) step();
    check("post_rst_valid", out_valid, 0);
    check("post_rst_done", done, 0);
    check("post_rst_cyc", cyc_count, 0);
    out_ready = 1'b1;
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
